// File: rtl/section_pair_consumer.sv
// Pair consumer: reads unsigned b_in then signed b_in2, writes the biased, saturated sum on res_out.
// Optional res_parity output when SECTION_PAIR_CONSUMER_PARITY_EN is defined.
module section_pair_consumer #(
    parameter int                 COUNT_W  = 16,
    parameter logic signed [31:0] RES_BIAS = 32'sd0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        b_in,
    input  logic               b_in_sync,
    output logic               b_in_notify,
    input  logic [31:0]        b_in2,
    input  logic               b_in2_sync,
    output logic               b_in2_notify,
    output logic [31:0]        res_out,
    input  logic               res_out_sync,
    output logic               res_out_notify,
    output logic               sat_flag,
    output logic [COUNT_W-1:0] pair_count
`ifdef SECTION_PAIR_CONSUMER_PARITY_EN
    ,
    output logic               res_parity
`endif
);

    typedef enum logic [1:0] {
        READ_A,
        READ_B,
        WRITE
    } state_t;

    state_t             state;
    logic [31:0]        a_reg;
    logic signed [34:0] sum;
    logic [31:0]        result;
    logic               clamp;

    // 35 bits hold any unsigned32 + signed32 + signed32 sum without overflow.
    always_comb begin
        sum    = $signed({3'b000, a_reg})
               + $signed({{3{b_in2[31]}}, b_in2})
               + $signed({{3{RES_BIAS[31]}}, RES_BIAS});
        result = sum[31:0];
        clamp  = 1'b0;
        if (sum[34:31] != {4{sum[34]}}) begin
            clamp  = 1'b1;
            result = sum[34] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= READ_A;
            a_reg          <= '0;
            b_in_notify    <= 1'b1;
            b_in2_notify   <= 1'b0;
            res_out_notify <= 1'b0;
            res_out        <= '0;
            sat_flag       <= 1'b0;
            pair_count     <= '0;
`ifdef SECTION_PAIR_CONSUMER_PARITY_EN
            res_parity     <= 1'b0;
`endif
        end else begin
            case (state)
                READ_A: begin
                    if (b_in_notify && b_in_sync) begin
                        a_reg        <= b_in;
                        b_in_notify  <= 1'b0;
                        b_in2_notify <= 1'b1;
                        state        <= READ_B;
                    end
                end
                READ_B: begin
                    if (b_in2_notify && b_in2_sync) begin
                        b_in2_notify   <= 1'b0;
                        res_out        <= result;
                        sat_flag       <= clamp;
                        res_out_notify <= 1'b1;
`ifdef SECTION_PAIR_CONSUMER_PARITY_EN
                        res_parity     <= ^result;
`endif
                        state          <= WRITE;
                    end
                end
                WRITE: begin
                    // res_out/sat_flag are left untouched so they persist after the handoff.
                    if (res_out_notify && res_out_sync) begin
                        res_out_notify <= 1'b0;
                        b_in_notify    <= 1'b1;
                        pair_count     <= pair_count + COUNT_W'(1);
                        state          <= READ_A;
                    end
                end
                default: begin
                    state          <= READ_A;
                    b_in_notify    <= 1'b1;
                    b_in2_notify   <= 1'b0;
                    res_out_notify <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_section_pair_consumer.sv
// Bench for section_pair_consumer: default, RES_BIAS=-1 and COUNT_W=4 instances share one stimulus.
module tb_section_pair_consumer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] b_in = '0;
    logic        b_in_sync = 1'b0;
    logic [31:0] b_in2 = '0;
    logic        b_in2_sync = 1'b0;
    logic        res_out_sync = 1'b0;

    logic        a_bn, a_b2n, a_rn, a_sat;
    logic [31:0] a_res;
    logic [15:0] a_cnt;
    logic        m_bn, m_b2n, m_rn, m_sat;
    logic [31:0] m_res;
    logic [15:0] m_cnt;
    logic        w_bn, w_b2n, w_rn, w_sat;
    logic [31:0] w_res;
    logic [3:0]  w_cnt;
`ifdef SECTION_PAIR_CONSUMER_PARITY_EN
    logic        a_par, m_par, w_par;
`endif

    int checks = 0;
    int errors = 0;
    int cnt    = 0;

    always #5 clk = ~clk;

    section_pair_consumer dut (
        .clk(clk), .rst(rst),
        .b_in(b_in), .b_in_sync(b_in_sync), .b_in_notify(a_bn),
        .b_in2(b_in2), .b_in2_sync(b_in2_sync), .b_in2_notify(a_b2n),
        .res_out(a_res), .res_out_sync(res_out_sync), .res_out_notify(a_rn),
        .sat_flag(a_sat), .pair_count(a_cnt)
`ifdef SECTION_PAIR_CONSUMER_PARITY_EN
        , .res_parity(a_par)
`endif
    );

    section_pair_consumer #(.RES_BIAS(-32'sd1)) dut_m1 (
        .clk(clk), .rst(rst),
        .b_in(b_in), .b_in_sync(b_in_sync), .b_in_notify(m_bn),
        .b_in2(b_in2), .b_in2_sync(b_in2_sync), .b_in2_notify(m_b2n),
        .res_out(m_res), .res_out_sync(res_out_sync), .res_out_notify(m_rn),
        .sat_flag(m_sat), .pair_count(m_cnt)
`ifdef SECTION_PAIR_CONSUMER_PARITY_EN
        , .res_parity(m_par)
`endif
    );

    section_pair_consumer #(.COUNT_W(4)) dut_w4 (
        .clk(clk), .rst(rst),
        .b_in(b_in), .b_in_sync(b_in_sync), .b_in_notify(w_bn),
        .b_in2(b_in2), .b_in2_sync(b_in2_sync), .b_in2_notify(w_b2n),
        .res_out(w_res), .res_out_sync(res_out_sync), .res_out_notify(w_rn),
        .sat_flag(w_sat), .pair_count(w_cnt)
`ifdef SECTION_PAIR_CONSUMER_PARITY_EN
        , .res_parity(w_par)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Notify triple of the default instance packed as {b_in, b_in2, res_out}.
    function automatic logic [31:0] nfy();
        return {29'd0, a_bn, a_b2n, a_rn};
    endfunction

    task automatic chk_reset_values(input string tag);
        chk({tag, "_notify"}, nfy(), 32'b100);
        chk({tag, "_res"}, a_res, 32'h0);
        chk({tag, "_sat"}, {31'd0, a_sat}, 32'd0);
        chk({tag, "_cnt"}, {16'd0, a_cnt}, 32'd0);
        chk({tag, "_cnt_w4"}, {28'd0, w_cnt}, 32'd0);
`ifdef SECTION_PAIR_CONSUMER_PARITY_EN
        chk({tag, "_par"}, {31'd0, a_par}, 32'd0);
`endif
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        sat;
        logic [31:0] res_m1;
        logic        sat_m1;
        int          stall;
    } vec_t;

    // One handshaked pair with res_out_sync held low for 'stall' cycles in WRITE.
    task automatic run_pair(input vec_t v, input int idx);
        string t;
        t = $sformatf("v%0d", idx);
        b_in = v.a;
        b_in_sync = 1'b1;
        tick();
        b_in_sync = 1'b0;
        chk({t, "_readb_notify"}, nfy(), 32'b010);
        b_in2 = v.b;
        b_in2_sync = 1'b1;
        tick();
        b_in2_sync = 1'b0;
        chk({t, "_write_notify"}, nfy(), 32'b001);
        chk({t, "_res"}, a_res, v.res);
        chk({t, "_sat"}, {31'd0, a_sat}, {31'd0, v.sat});
        chk({t, "_res_m1"}, m_res, v.res_m1);
        chk({t, "_sat_m1"}, {31'd0, m_sat}, {31'd0, v.sat_m1});
`ifdef SECTION_PAIR_CONSUMER_PARITY_EN
        chk({t, "_par"}, {31'd0, a_par}, {31'd0, ^v.res});
`endif
        for (int s = 0; s < v.stall; s++) begin
            tick();
            chk({t, "_stall_notify"}, nfy(), 32'b001);
            chk({t, "_stall_res"}, a_res, v.res);
            chk({t, "_stall_sat"}, {31'd0, a_sat}, {31'd0, v.sat});
            chk({t, "_stall_cnt"}, {16'd0, a_cnt}, 32'(cnt % 65536));
        end
        res_out_sync = 1'b1;
        tick();
        res_out_sync = 1'b0;
        cnt++;
        chk({t, "_done_notify"}, nfy(), 32'b100);
        chk({t, "_cnt"}, {16'd0, a_cnt}, 32'(cnt % 65536));
        chk({t, "_cnt_w4"}, {28'd0, w_cnt}, 32'(cnt % 16));
        chk({t, "_res_hold"}, a_res, v.res);
        $display("pair %0d a=0x%08h b=0x%08h res=0x%08h sat=%0b res_m1=0x%08h cnt=%0d",
                 idx, v.a, v.b, a_res, a_sat, m_res, a_cnt);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{32'd13,        32'hFFFF_FFF9, 32'd6,         1'b0, 32'd5,         1'b0, 0};
        vecs[1] = '{32'hFFFF_FFFF, 32'd5,         32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF, 1'b1, 5};
        vecs[2] = '{32'd0,         32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b1, 1};
        vecs[3] = '{32'd3,         32'd4,         32'd7,         1'b0, 32'd6,         1'b0, 0};
        vecs[4] = '{32'h7FFF_FFFF, 32'd0,         32'h7FFF_FFFF, 1'b0, 32'h7FFF_FFFE, 1'b0, 2};
        vecs[5] = '{32'h8000_0000, 32'd0,         32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF, 1'b0, 0};
        vecs[6] = '{32'h8000_0000, 32'h8000_0000, 32'd0,         1'b0, 32'hFFFF_FFFF, 1'b0, 0};
        vecs[7] = '{32'd100,       32'hFFFF_FF38, 32'hFFFF_FF9C, 1'b0, 32'hFFFF_FF9B, 1'b0, 3};

        #2 rst = 1'b1;
        tick();
        tick();
        chk_reset_values("reset");
        rst = 1'b0;

        // Full-rate pair with every sync high: one pair per 3 cycles.
        b_in = 32'd13;
        b_in2 = 32'hFFFF_FFF9;
        b_in_sync = 1'b1;
        b_in2_sync = 1'b1;
        res_out_sync = 1'b1;
        tick();
        chk("rate_c1_notify", nfy(), 32'b010);
        tick();
        chk("rate_c2_notify", nfy(), 32'b001);
        chk("rate_c2_res", a_res, 32'd6);
        chk("rate_c2_sat", {31'd0, a_sat}, 32'd0);
        chk("rate_c2_res_m1", m_res, 32'd5);
        tick();
        b_in_sync = 1'b0;
        b_in2_sync = 1'b0;
        res_out_sync = 1'b0;
        cnt++;
        chk("rate_c3_notify", nfy(), 32'b100);
        chk("rate_c3_cnt", {16'd0, a_cnt}, 32'd1);
        chk("rate_c3_res_hold", a_res, 32'd6);
        $display("pair rate a=0x0000000d b=0xfffffff9 res=0x%08h cnt=%0d", a_res, a_cnt);

        for (int i = 0; i < 8; i++) run_pair(vecs[i], i);

        // b_in2_sync in READ_A must be ignored.
        b_in2 = 32'd77;
        b_in2_sync = 1'b1;
        tick();
        tick();
        b_in2_sync = 1'b0;
        chk("ign_b2_notify", nfy(), 32'b100);
        chk("ign_b2_cnt", {16'd0, a_cnt}, 32'(cnt));
        chk("ign_b2_res", a_res, 32'hFFFF_FF9C);
        $display("ignore b_in2_sync in READ_A notify=%03b", nfy());

        // Asynchronous reset while in READ_B discards the half pair.
        b_in = 32'd50;
        b_in_sync = 1'b1;
        tick();
        b_in_sync = 1'b0;
        chk("mid_readb_notify", nfy(), 32'b010);
        rst = 1'b1;
        #1;
        chk_reset_values("mid_reset");
        tick();
        rst = 1'b0;
        cnt = 0;
        $display("reset in READ_B notify=%03b cnt=%0d", nfy(), a_cnt);
        run_pair(vecs[3], 3);

        // 16 more pairs: the 4-bit counter returns to its value before the loop.
        for (int i = 0; i < 16; i++) run_pair(vecs[i % 8], 100 + i);
        chk("wrap_w4", {28'd0, w_cnt}, 32'd1);
        chk("wrap_16", {16'd0, a_cnt}, 32'd17);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
